multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the MIPS datapath: FETCH/DECODE/EXEC/MEM/WB FSM.
//  Drives every datapath control select plus PC/IR write enables and a req/ready handshake to a variable-latency DM.
//  Sits beside the datapath top; consumes opcode/func from the IR splitter and jumpEn from CMP.
// PARAMETERS
//  DM_TIMEOUT  15  max cycles MEM waits for dmReady before bus error (1..255)
//  CNT_W       32  width of retired-instruction counter
// PORTS
//  clk              in   1      rising-edge clock
//  reset            in   1      asynchronous, active-low reset (0 = reset)
//  opcode           in   6      IR[31:26]
//  func             in   6      IR[5:0]
//  jumpEn           in   1      CMP branch-taken
//  dmReady          in   1      DM access complete
//  pcWriteEn        out  1      PC loads npc this cycle
//  irWriteEn        out  1      IR latches IM output
//  npcOp            out  2      PC4 / BRANCH / J26 / JR
//  writeRegSel      out  2      GRF A3: RT / RD / RA
//  grfWriteEn       out  1      GRF write strobe
//  writeRegDataSel  out  2      GRF WD: ALURESULT / MEMRD / PC_4
//  extUnsignedSel   out  1      1 = zero-extend imm16
//  aluSrcSel        out  1      ALU srcB: GRFRD2 / IMM32
//  shamtSel         out  1      shamt: 16 / sa
//  aluOp            out  4      ALU function
//  branchOp         out  3      CMP function
//  dmReq            out  1      DM access request
//  dmWriteEn        out  1      DM write (valid only with dmReq)
//  dmOp             out  2      DM width
//  busErr           out  1      one-cycle pulse on DM timeout
//  illegal          out  1      one-cycle pulse, undecoded instruction
//  instret          out  CNT_W  retired instructions
//  state            out  3      current FSM state (debug)
// BEHAVIOUR
//  - Reset (async, reset==0): state=FETCH, instret=0, all enables/pulses 0, selects 0; held while reset==0.
//  - Outputs are Moore: decoded from state + opcode/func (IR stable after FETCH). Nothing registered but state, wait counter, instret.
//  - FETCH: irWriteEn=1 -> DECODE. DECODE: no enables -> EXEC; undecoded -> illegal=1, treated as nop.
//  - EXEC: ALU selects driven per class.
//      addu/subu/sll/ori/lui/nop -> WB.  lw/sw -> MEM.
//      beq: branchOp=EQ, pcWriteEn=1, npcOp=jumpEn?BRANCH:PC4 -> FETCH.
//      jal: pcWriteEn=1, npcOp=J26, grfWriteEn=1, A3=RA, WD=PC_4 -> FETCH.
//      jr:  pcWriteEn=1, npcOp=JR -> FETCH.
//  - MEM: dmReq=1 (dmWriteEn=1 for sw) held stable until dmReady sampled 1; wait counter counts cycles in MEM.
//      lw+ready -> WB; sw+ready -> pcWriteEn=1 (PC4) -> FETCH.
//      counter reaching DM_TIMEOUT without ready: busErr=1, dmReq drops, pcWriteEn=1 (PC4), no GRF write -> FETCH.
//      dmReady outside MEM ignored; ready on the same cycle as timeout counts as success.
//  - WB: grfWriteEn=1 (A3/WD per class), pcWriteEn=1 npcOp=PC4 -> FETCH.
//  - instret +1 on every cycle with pcWriteEn=1 (including timeout/illegal); wraps at 2^CNT_W.
//  - Exactly one pcWriteEn per instruction; grfWriteEn at most once.
//  - Latency: branch/jump 3 cycles, ALU 4, sw 4+waits, lw 5+waits.
//  - grfWriteEn with A3 resolving to $0 is still issued; GRF discards it.
// STRUCTURE
//  - def.v: state encodings (FETCH=0..WB=4), opcode/func constants, CU_NPC_*, CU_GRF_A3_*, CU_GRF_WD_*, CU_ALU_*, ALU/CMP/DM op codes.
//  - Sub-module instr_decode (combinational): opcode/func -> class + static selects; FSM gates the enables.
// TESTING
//  - reset low mid-MEM with dmReq=1 -> next edge state=FETCH, dmReq=0, instret=0.
//  - addu $3,$1,$2 -> FETCH,DECODE,EXEC,WB; grfWriteEn only in WB, A3=RD, WD=ALURESULT; instret 0->1.
//  - lw, dmReady after 3 wait cycles -> dmReq high 4 cycles, then WB with WD=MEMRD; total 8 cycles.
//  - sw, dmReady never -> busErr pulse at cycle 15 of MEM, no grfWriteEn, PC4, FETCH next.
//  - beq jumpEn=1 then 0 -> npcOp=BRANCH then PC4, each 3 cycles; jal -> A3=RA, WD=PC_4, npcOp=J26.
//  - opcode 6'h3f -> illegal pulse in DECODE, no GRF/DM writes, PC4 in WB, instret increments.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl_pkg
//
// Purpose:
//    Shared definitions for the multi-cycle MIPS sequencer: FSM state
//    encodings, opcode/func constants, the control-select codes the
//    datapath understands, and the decoded-instruction record passed from
//    instr_decode to the FSM.
//
// Contents:
//    ctrlState_e   FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4
//    instrClass_e  sequencing class of the instruction held in the IR
//    decodeInfo_t  class plus all static datapath selects
//    isMemClass()  true for classes that visit the MEM state
// ---------------------------------------------------------------------------
package multi_cycle_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } ctrlState_e;

   // Opcode field values (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // Function field values for R-type (IR[5:0]); nop is sll $0,$0,0
   localparam logic [5:0] FUNC_SLL  = 6'h00;
   localparam logic [5:0] FUNC_JR   = 6'h08;
   localparam logic [5:0] FUNC_ADDU = 6'h21;
   localparam logic [5:0] FUNC_SUBU = 6'h23;

   // Next-PC source
   localparam logic [1:0] CU_NPC_PC4    = 2'd0;
   localparam logic [1:0] CU_NPC_BRANCH = 2'd1;
   localparam logic [1:0] CU_NPC_J26    = 2'd2;
   localparam logic [1:0] CU_NPC_JR     = 2'd3;

   // GRF write-address (A3) source
   localparam logic [1:0] CU_GRF_A3_RT = 2'd0;
   localparam logic [1:0] CU_GRF_A3_RD = 2'd1;
   localparam logic [1:0] CU_GRF_A3_RA = 2'd2;

   // GRF write-data (WD) source
   localparam logic [1:0] CU_GRF_WD_ALURESULT = 2'd0;
   localparam logic [1:0] CU_GRF_WD_MEMRD     = 2'd1;
   localparam logic [1:0] CU_GRF_WD_PC_4      = 2'd2;

   // ALU operand-B and shift-amount sources
   localparam logic CU_ALU_GRFRD2 = 1'b0;
   localparam logic CU_ALU_IMM32  = 1'b1;
   localparam logic CU_SHAMT_16   = 1'b0;
   localparam logic CU_SHAMT_SA   = 1'b1;

   // ALU function codes
   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_OR  = 4'd2;
   localparam logic [3:0] ALU_SLL = 4'd3;
   localparam logic [3:0] ALU_LUI = 4'd4;

   // CMP function codes
   localparam logic [2:0] CMP_NONE = 3'd0;
   localparam logic [2:0] CMP_EQ   = 3'd1;

   // DM access width
   localparam logic [1:0] DM_WORD = 2'd0;
   localparam logic [1:0] DM_HALF = 2'd1;
   localparam logic [1:0] DM_BYTE = 2'd2;

   typedef enum logic [2:0] {
      CLS_ALU     = 3'd0,
      CLS_LOAD    = 3'd1,
      CLS_STORE   = 3'd2,
      CLS_BRANCH  = 3'd3,
      CLS_JAL     = 3'd4,
      CLS_JR      = 3'd5,
      CLS_ILLEGAL = 3'd6
   } instrClass_e;

   typedef struct packed {
      instrClass_e cls;
      logic [3:0]  aluOp;
      logic        aluSrcSel;
      logic        extUnsignedSel;
      logic        shamtSel;
      logic [2:0]  branchOp;
      logic [1:0]  writeRegSel;
      logic [1:0]  writeRegDataSel;
      logic [1:0]  dmOp;
   } decodeInfo_t;

   function automatic logic isMemClass(input instrClass_e cls);
      return (cls == CLS_LOAD) || (cls == CLS_STORE);
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
//
// Purpose:
//    Purely combinational decoder. Maps the IR opcode/func fields onto an
//    instruction class and the static datapath selects for that class.
//    It never produces enables or strobes; the sequencer FSM decides when
//    those fire.
//
// Ports:
//    opcode_i  in   6   IR[31:26]
//    func_i    in   6   IR[5:0], only meaningful for R-type
//    info_o    out      decodeInfo_t: class + static selects
// ---------------------------------------------------------------------------
module instr_decode
   import multi_cycle_ctrl_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [5:0]  func_i,
   output decodeInfo_t info_o
);

   // Start from an all-zero, illegal record so any encoding we do not
   // recognise falls through as a nop that only advances the PC.
   always_comb begin
      info_o     = '0;
      info_o.cls = CLS_ILLEGAL;
      case (opcode_i)
         OP_RTYPE: begin
            case (func_i)
               FUNC_ADDU: begin
                  info_o.cls         = CLS_ALU;
                  info_o.aluOp       = ALU_ADD;
                  info_o.aluSrcSel   = CU_ALU_GRFRD2;
                  info_o.writeRegSel = CU_GRF_A3_RD;
               end
               FUNC_SUBU: begin
                  info_o.cls         = CLS_ALU;
                  info_o.aluOp       = ALU_SUB;
                  info_o.aluSrcSel   = CU_ALU_GRFRD2;
                  info_o.writeRegSel = CU_GRF_A3_RD;
               end
               FUNC_SLL: begin
                  info_o.cls         = CLS_ALU;
                  info_o.aluOp       = ALU_SLL;
                  info_o.shamtSel    = CU_SHAMT_SA;
                  info_o.writeRegSel = CU_GRF_A3_RD;
               end
               FUNC_JR: begin
                  info_o.cls = CLS_JR;
               end
               default: info_o.cls = CLS_ILLEGAL;
            endcase
         end
         OP_ORI: begin
            info_o.cls            = CLS_ALU;
            info_o.aluOp          = ALU_OR;
            info_o.aluSrcSel      = CU_ALU_IMM32;
            info_o.extUnsignedSel = 1'b1;
            info_o.writeRegSel    = CU_GRF_A3_RT;
         end
         OP_LUI: begin
            info_o.cls            = CLS_ALU;
            info_o.aluOp          = ALU_LUI;
            info_o.aluSrcSel      = CU_ALU_IMM32;
            info_o.extUnsignedSel = 1'b1;
            info_o.shamtSel       = CU_SHAMT_16;
            info_o.writeRegSel    = CU_GRF_A3_RT;
         end
         OP_LW: begin
            info_o.cls             = CLS_LOAD;
            info_o.aluOp           = ALU_ADD;
            info_o.aluSrcSel       = CU_ALU_IMM32;
            info_o.writeRegSel     = CU_GRF_A3_RT;
            info_o.writeRegDataSel = CU_GRF_WD_MEMRD;
            info_o.dmOp            = DM_WORD;
         end
         OP_SW: begin
            info_o.cls       = CLS_STORE;
            info_o.aluOp     = ALU_ADD;
            info_o.aluSrcSel = CU_ALU_IMM32;
            info_o.dmOp      = DM_WORD;
         end
         OP_BEQ: begin
            info_o.cls      = CLS_BRANCH;
            info_o.branchOp = CMP_EQ;
         end
         OP_JAL: begin
            info_o.cls             = CLS_JAL;
            info_o.writeRegSel     = CU_GRF_A3_RA;
            info_o.writeRegDataSel = CU_GRF_WD_PC_4;
         end
         default: info_o.cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Purpose:
//    Multi-cycle sequencer for the MIPS datapath. Walks each instruction
//    through FETCH / DECODE / EXEC / MEM / WB, drives the datapath selects,
//    PC/IR write enables and a req/ready handshake to a variable-latency
//    data memory, and counts retired instructions.
//
// Parameters:
//    DM_TIMEOUT  cycles MEM waits for dmReady before a bus error (1..255)
//    CNT_W       width of the retired-instruction counter
//
// Ports:
//    clk, reset (async, active-low)
//    opcode, func, jumpEn, dmReady            inputs from IR / CMP / DM
//    pcWriteEn, irWriteEn, grfWriteEn         write enables
//    npcOp, writeRegSel, writeRegDataSel      PC / GRF source selects
//    extUnsignedSel, aluSrcSel, shamtSel,
//    aluOp, branchOp                          EXT / ALU / CMP controls
//    dmReq, dmWriteEn, dmOp                   DM handshake
//    busErr, illegal                          one-cycle event pulses
//    instret, state                           counter and debug state
// ---------------------------------------------------------------------------
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int unsigned DM_TIMEOUT = 15,
   parameter int unsigned CNT_W      = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             jumpEn,
   input  logic             dmReady,
   output logic             pcWriteEn,
   output logic             irWriteEn,
   output logic [1:0]       npcOp,
   output logic [1:0]       writeRegSel,
   output logic             grfWriteEn,
   output logic [1:0]       writeRegDataSel,
   output logic             extUnsignedSel,
   output logic             aluSrcSel,
   output logic             shamtSel,
   output logic [3:0]       aluOp,
   output logic [2:0]       branchOp,
   output logic             dmReq,
   output logic             dmWriteEn,
   output logic [1:0]       dmOp,
   output logic             busErr,
   output logic             illegal,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       state
);

   // The wait counter holds (cycles already spent in MEM); the last
   // allowed MEM cycle is therefore the one where it equals DM_TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(DM_TIMEOUT - 1);

   ctrlState_e       state_q, state_d;
   logic [7:0]       waitCnt_q, waitCnt_d;
   logic [CNT_W-1:0] instret_q;
   decodeInfo_t      dec;
   logic             waitExpired;

   instr_decode uDecode (
      .opcode_i (opcode),
      .func_i   (func),
      .info_o   (dec)
   );

   assign waitExpired = (waitCnt_q == WAIT_LAST);

   // State register and MEM wait counter. Reset parks the FSM in FETCH
   // immediately, even in the middle of a memory access.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= FETCH;
         waitCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         waitCnt_q <= waitCnt_d;
      end
   end

   // Next-state logic. The wait counter is cleared everywhere except while
   // MEM keeps waiting, so every memory access starts counting from zero.
   // A ready arriving in the final allowed cycle wins over the timeout.
   always_comb begin
      state_d   = state_q;
      waitCnt_d = '0;
      case (state_q)
         FETCH:  state_d = DECODE;
         DECODE: state_d = EXEC;
         EXEC: begin
            if (isMemClass(dec.cls)) begin
               state_d = MEM;
            end else if ((dec.cls == CLS_BRANCH) || (dec.cls == CLS_JAL) ||
                         (dec.cls == CLS_JR)) begin
               state_d = FETCH;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (dmReady) begin
               state_d = (dec.cls == CLS_LOAD) ? WB : FETCH;
            end else if (waitExpired) begin
               state_d = FETCH;
            end else begin
               state_d   = MEM;
               waitCnt_d = waitCnt_q + 8'd1;
            end
         end
         WB:      state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   // Output decode. Static selects follow the decoded IR once it is valid
   // (everything after FETCH); enables and pulses are gated per state.
   // While reset is held low every output is forced to zero so nothing in
   // the datapath is written during reset.
   always_comb begin
      pcWriteEn       = 1'b0;
      irWriteEn       = 1'b0;
      npcOp           = CU_NPC_PC4;
      writeRegSel     = CU_GRF_A3_RT;
      grfWriteEn      = 1'b0;
      writeRegDataSel = CU_GRF_WD_ALURESULT;
      extUnsignedSel  = 1'b0;
      aluSrcSel       = CU_ALU_GRFRD2;
      shamtSel        = CU_SHAMT_16;
      aluOp           = ALU_ADD;
      branchOp        = CMP_NONE;
      dmReq           = 1'b0;
      dmWriteEn       = 1'b0;
      dmOp            = DM_WORD;
      busErr          = 1'b0;
      illegal         = 1'b0;

      if (state_q != FETCH) begin
         writeRegSel     = dec.writeRegSel;
         writeRegDataSel = dec.writeRegDataSel;
         extUnsignedSel  = dec.extUnsignedSel;
         aluSrcSel       = dec.aluSrcSel;
         shamtSel        = dec.shamtSel;
         aluOp           = dec.aluOp;
         branchOp        = dec.branchOp;
         dmOp            = dec.dmOp;
      end

      case (state_q)
         FETCH: irWriteEn = 1'b1;
         DECODE: illegal = (dec.cls == CLS_ILLEGAL);
         EXEC: begin
            case (dec.cls)
               CLS_BRANCH: begin
                  pcWriteEn = 1'b1;
                  npcOp     = jumpEn ? CU_NPC_BRANCH : CU_NPC_PC4;
               end
               CLS_JAL: begin
                  pcWriteEn  = 1'b1;
                  npcOp      = CU_NPC_J26;
                  grfWriteEn = 1'b1;
               end
               CLS_JR: begin
                  pcWriteEn = 1'b1;
                  npcOp     = CU_NPC_JR;
               end
               default: ;
            endcase
         end
         MEM: begin
            dmReq     = 1'b1;
            dmWriteEn = (dec.cls == CLS_STORE);
            if (dmReady) begin
               pcWriteEn = (dec.cls == CLS_STORE);
            end else if (waitExpired) begin
               busErr    = 1'b1;
               pcWriteEn = 1'b1;
            end
         end
         WB: begin
            pcWriteEn  = 1'b1;
            grfWriteEn = (dec.cls == CLS_ALU) || (dec.cls == CLS_LOAD);
         end
         default: ;
      endcase

      if (!reset) begin
         pcWriteEn       = 1'b0;
         irWriteEn       = 1'b0;
         npcOp           = CU_NPC_PC4;
         writeRegSel     = CU_GRF_A3_RT;
         grfWriteEn      = 1'b0;
         writeRegDataSel = CU_GRF_WD_ALURESULT;
         extUnsignedSel  = 1'b0;
         aluSrcSel       = CU_ALU_GRFRD2;
         shamtSel        = CU_SHAMT_16;
         aluOp           = ALU_ADD;
         branchOp        = CMP_NONE;
         dmReq           = 1'b0;
         dmWriteEn       = 1'b0;
         dmOp            = DM_WORD;
         busErr          = 1'b0;
         illegal         = 1'b0;
      end
   end

   // Retired-instruction counter: every instruction issues exactly one PC
   // write, so counting PC writes counts instructions, including ones that
   // ended in a bus error or were undecoded. Wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instret_q <= '0;
      end else if (pcWriteEn) begin
         instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign instret = instret_q;
   assign state   = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
//
// Purpose:
//    Self-checking bench for multi_cycle_ctrl. Each instruction is described
//    by its class; a reference timeline (cycle count, when the PC write,
//    GRF write, DM request and pulses must appear) is derived from the
//    instruction latencies and compared cycle by cycle against the DUT.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

   localparam int TIMEOUT = 15;

   localparam logic [2:0] K_ALU     = 3'd0;
   localparam logic [2:0] K_LOAD    = 3'd1;
   localparam logic [2:0] K_STORE   = 3'd2;
   localparam logic [2:0] K_BEQ     = 3'd3;
   localparam logic [2:0] K_JAL     = 3'd4;
   localparam logic [2:0] K_JR      = 3'd5;
   localparam logic [2:0] K_ILLEGAL = 3'd6;

   typedef struct packed {
      logic [5:0] op;
      logic [5:0] fn;
      logic [2:0] kind;
      logic [3:0] aluOp;
      logic [1:0] a3;
      logic [1:0] wd;
   } instr_t;

   logic        clk;
   logic        reset;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic        jumpEn;
   logic        dmReady;
   logic        pcWriteEn;
   logic        irWriteEn;
   logic [1:0]  npcOp;
   logic [1:0]  writeRegSel;
   logic        grfWriteEn;
   logic [1:0]  writeRegDataSel;
   logic        extUnsignedSel;
   logic        aluSrcSel;
   logic        shamtSel;
   logic [3:0]  aluOp;
   logic [2:0]  branchOp;
   logic        dmReq;
   logic        dmWriteEn;
   logic [1:0]  dmOp;
   logic        busErr;
   logic        illegal;
   logic [31:0] instret;
   logic [2:0]  state;

   int          checkCount;
   int          errorCount;
   logic [31:0] retired;

   multi_cycle_ctrl #(
      .DM_TIMEOUT (TIMEOUT),
      .CNT_W      (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .opcode          (opcode),
      .func            (func),
      .jumpEn          (jumpEn),
      .dmReady         (dmReady),
      .pcWriteEn       (pcWriteEn),
      .irWriteEn       (irWriteEn),
      .npcOp           (npcOp),
      .writeRegSel     (writeRegSel),
      .grfWriteEn      (grfWriteEn),
      .writeRegDataSel (writeRegDataSel),
      .extUnsignedSel  (extUnsignedSel),
      .aluSrcSel       (aluSrcSel),
      .shamtSel        (shamtSel),
      .aluOp           (aluOp),
      .branchOp        (branchOp),
      .dmReq           (dmReq),
      .dmWriteEn       (dmWriteEn),
      .dmOp            (dmOp),
      .busErr          (busErr),
      .illegal         (illegal),
      .instret         (instret),
      .state           (state)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Instruction table: index -> encoding and the architectural expectations
   function automatic instr_t pickInstr(input int idx, input logic [5:0] rnd);
      instr_t t;
      t.op = 6'h00; t.fn = rnd; t.kind = K_ALU; t.aluOp = 4'd0; t.a3 = 2'd0; t.wd = 2'd0;
      case (idx)
         0:  begin t.fn = 6'h21; t.aluOp = 4'd0; t.a3 = 2'd1; end
         1:  begin t.fn = 6'h23; t.aluOp = 4'd1; t.a3 = 2'd1; end
         2:  begin t.fn = 6'h00; t.aluOp = 4'd3; t.a3 = 2'd1; end
         3:  begin t.op = 6'h0d; t.aluOp = 4'd2; end
         4:  begin t.op = 6'h0f; t.aluOp = 4'd4; end
         5:  begin t.op = 6'h23; t.kind = K_LOAD; t.wd = 2'd1; end
         6:  begin t.op = 6'h2b; t.kind = K_STORE; end
         7:  begin t.op = 6'h04; t.kind = K_BEQ; end
         8:  begin t.op = 6'h03; t.kind = K_JAL; t.a3 = 2'd2; t.wd = 2'd2; end
         9:  begin t.fn = 6'h08; t.kind = K_JR; end
         10: begin t.op = 6'h3f; t.kind = K_ILLEGAL; end
         default: begin t.fn = 6'h2a; t.kind = K_ILLEGAL; end
      endcase
      return t;
   endfunction

   // Runs one instruction from its FETCH cycle to its last cycle.
   // Entered and left at (rising edge + 1).
   task automatic applyStimulus(input instr_t ins, input logic jmp, input int delay);
      int   memCycles;
      int   len;
      int   expState;
      logic memOk;
      logic isMem;
      logic inMem;
      logic last;
      logic writesGrf;
      logic [1:0] expNpc;

      isMem     = (ins.kind == K_LOAD) || (ins.kind == K_STORE);
      memOk     = (delay < TIMEOUT);
      memCycles = memOk ? delay + 1 : TIMEOUT;
      case (ins.kind)
         K_BEQ, K_JAL, K_JR: len = 3;
         K_STORE:            len = 3 + memCycles;
         K_LOAD:             len = memOk ? 4 + memCycles : 3 + memCycles;
         default:            len = 4;
      endcase
      writesGrf = (ins.kind == K_ALU) || (ins.kind == K_JAL) ||
                  ((ins.kind == K_LOAD) && memOk);
      expNpc = (ins.kind == K_BEQ) ? (jmp ? 2'd1 : 2'd0) :
               (ins.kind == K_JAL) ? 2'd2 :
               (ins.kind == K_JR)  ? 2'd3 : 2'd0;

      opcode = ins.op;
      func   = ins.fn;
      jumpEn = jmp;
      for (int c = 0; c < len; c++) begin
         inMem    = isMem && (c >= 3) && (c < 3 + memCycles);
         expState = (c < 3) ? c : (inMem ? 3 : 4);
         last     = (c == len - 1);
         if (inMem) dmReady = (c - 3 == delay);
         else       dmReady = 1'($urandom_range(0, 1));
         @(negedge clk);
         checkOutput("state",      32'(state),      32'(expState));
         checkOutput("pcWriteEn",  32'(pcWriteEn),  32'(last));
         checkOutput("irWriteEn",  32'(irWriteEn),  32'(c == 0));
         checkOutput("grfWriteEn", 32'(grfWriteEn), 32'(last && writesGrf));
         checkOutput("dmReq",      32'(dmReq),      32'(inMem));
         checkOutput("dmWriteEn",  32'(dmWriteEn),  32'(inMem && (ins.kind == K_STORE)));
         checkOutput("busErr",     32'(busErr),     32'(last && isMem && !memOk));
         checkOutput("illegal",    32'(illegal),    32'((c == 1) && (ins.kind == K_ILLEGAL)));
         checkOutput("instret",    instret,         retired);
         if (last) checkOutput("npcOp", 32'(npcOp), 32'(expNpc));
         if (last && writesGrf) begin
            checkOutput("writeRegSel",     32'(writeRegSel),     32'(ins.a3));
            checkOutput("writeRegDataSel", 32'(writeRegDataSel), 32'(ins.wd));
         end
         if ((c == 2) && ((ins.kind == K_ALU) || isMem))
            checkOutput("aluOp", 32'(aluOp), 32'(ins.aluOp));
         if ((c == 2) && (ins.kind == K_BEQ))
            checkOutput("branchOp", 32'(branchOp), 32'd1);
         @(posedge clk);
         #1;
      end
      retired = retired + 32'd1;
   endtask

   initial begin
      int   idx;
      int   delay;
      logic jmp;

      checkCount = 0;
      errorCount = 0;
      retired    = 32'd0;
      reset   = 1'b0;
      opcode  = 6'h00;
      func    = 6'h00;
      jumpEn  = 1'b0;
      dmReady = 1'b0;

      // Held in reset: FETCH, nothing enabled, counter clear
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_state",     32'(state),     32'd0);
      checkOutput("rst_irWriteEn", 32'(irWriteEn), 32'd0);
      checkOutput("rst_pcWriteEn", 32'(pcWriteEn), 32'd0);
      checkOutput("rst_instret",   instret,        32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Directed cases
      applyStimulus(pickInstr(0, 6'h00), 1'b0, 0);
      applyStimulus(pickInstr(5, 6'h00), 1'b0, 3);
      applyStimulus(pickInstr(6, 6'h00), 1'b0, 99);
      applyStimulus(pickInstr(5, 6'h00), 1'b0, 99);
      applyStimulus(pickInstr(6, 6'h00), 1'b0, TIMEOUT - 1);
      applyStimulus(pickInstr(7, 6'h00), 1'b1, 0);
      applyStimulus(pickInstr(7, 6'h00), 1'b0, 0);
      applyStimulus(pickInstr(8, 6'h00), 1'b0, 0);
      applyStimulus(pickInstr(10, 6'h00), 1'b0, 0);

      // Reset asserted while MEM is requesting
      opcode  = 6'h23;
      func    = 6'h00;
      dmReady = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("midmem_dmReq", 32'(dmReq), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midrst_state",   32'(state), 32'd0);
      checkOutput("midrst_dmReq",   32'(dmReq), 32'd0);
      checkOutput("midrst_instret", instret,    32'd0);
      retired = 32'd0;
      @(posedge clk);
      #1;
      checkOutput("midrst_hold", 32'(state), 32'd0);
      reset = 1'b1;

      // Randomized instruction stream
      repeat (200) begin
         idx   = $urandom_range(0, 11);
         delay = $urandom_range(0, 18);
         jmp   = 1'($urandom_range(0, 1));
         applyStimulus(pickInstr(idx, 6'($urandom_range(0, 63))), jmp, delay);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
